// File: rtl/mb_crc_seq.sv
// Modbus RTU framer: passes payload bytes downstream, then appends the CRC-16 (low byte first).
// Optional payload-length check (254 bytes max) with a drop state: define MB_CRC_LEN_CHK_EN.
module mb_crc_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [7:0]  crc_data,
    output logic        crc_init,
    output logic        crc_en,
    input  logic [15:0] crc_result,
    output logic        busy
`ifdef MB_CRC_LEN_CHK_EN
    ,
    output logic        frame_err
`endif
);

    // state  | meaning
    // IDLE   | waiting for the first byte of a frame (byte not consumed)
    // INIT   | one bubble cycle, engine preloaded to 0xFFFF
    // DATA   | payload pass-through, engine absorbs every handshake
    // CRC_LO | emitting crc_result[7:0]
    // CRC_HI | emitting crc_result[15:8] with m_last
    // DROP   | over-length frame, discard until s_last (length check only)
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DATA,
        CRC_LO,
        CRC_HI
`ifdef MB_CRC_LEN_CHK_EN
        ,
        DROP
`endif
    } state_t;

    state_t state;

`ifdef MB_CRC_LEN_CHK_EN
    logic [7:0] pay_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            crc_init <= 1'b0;
            busy     <= 1'b0;
`ifdef MB_CRC_LEN_CHK_EN
            frame_err <= 1'b0;
            pay_cnt   <= 8'd0;
`endif
        end else begin
            crc_init <= 1'b0;
`ifdef MB_CRC_LEN_CHK_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        state    <= INIT;
                        crc_init <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                INIT: begin
                    state <= DATA;
`ifdef MB_CRC_LEN_CHK_EN
                    pay_cnt <= 8'd0;
`endif
                end
                DATA: begin
                    if (s_valid && m_ready) begin
`ifdef MB_CRC_LEN_CHK_EN
                        pay_cnt <= pay_cnt + 8'd1;
                        // pay_cnt holds the handshakes before this one, so 253 means byte 254
                        if (!s_last && pay_cnt == 8'd253) begin
                            state     <= DROP;
                            frame_err <= 1'b1;
                        end else if (s_last) begin
                            state <= CRC_LO;
                        end
`else
                        if (s_last) begin
                            state <= CRC_LO;
                        end
`endif
                    end
                end
                CRC_LO: begin
                    if (m_ready) begin
                        state <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (m_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef MB_CRC_LEN_CHK_EN
                DROP: begin
                    if (s_valid && s_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Payload path stays combinational so bytes flow at one per clock with no extra latency.
    always_comb begin
        s_ready  = 1'b0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        crc_data = 8'h00;
        crc_en   = 1'b0;
        case (state)
            DATA: begin
                m_data   = s_data;
                m_valid  = s_valid;
                s_ready  = m_ready;
                crc_data = s_data;
                crc_en   = s_valid && m_ready;
            end
            CRC_LO: begin
                m_data  = crc_result[7:0];
                m_valid = 1'b1;
            end
            CRC_HI: begin
                m_data  = crc_result[15:8];
                m_valid = 1'b1;
                m_last  = 1'b1;
            end
`ifdef MB_CRC_LEN_CHK_EN
            DROP: begin
                s_ready = 1'b1;
            end
`endif
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

endmodule
